// File: rtl/wsm_pkg.sv
// Shared constants for the write_state_machine bus sequencer: state width and
// the legacy-compatible state encodings.
package wsm_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'b00;
    localparam logic [STATE_W-1:0] INIT = 2'b01;
    localparam logic [STATE_W-1:0] WAIT = 2'b10;
    localparam logic [STATE_W-1:0] STOP = 2'b11;

endpackage

// File: rtl/write_state_machine_if.sv
// CPU request / slave bus bundle seen by write_state_machine. The sequencer is
// the bus master; the slave modport is the memory/CPU side driving requests and ack_n.
interface write_state_machine_if;
    import wsm_pkg::*;

    logic               ack_n;
    logic               mr;
    logic               mw;
    logic [STATE_W-1:0] sm_state;
    logic               as_n;
    logic               stop_n;
    logic               wr_n;
    logic               in_init;
    logic               busy;
    logic               timeout;

    modport master (
        input  ack_n, mr, mw,
        output sm_state, as_n, stop_n, wr_n, in_init, busy, timeout
    );

    modport slave (
        output ack_n, mr, mw,
        input  sm_state, as_n, stop_n, wr_n, in_init, busy, timeout
    );

endinterface

// File: rtl/wsm_timeout_counter.sv
// WAIT-state cycle counter: cleared on WAIT entry, counts while in WAIT and
// flags the last permitted cycle so the sequencer can abort to STOP.
module wsm_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && cnt != W'(LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // During WAIT cycle k the count holds k-1, so LIMIT-1 marks the final cycle.
    assign expire = count && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/write_state_machine.sv
// Bus-master handshake sequencer: IDLE -> INIT -> WAIT (until ack_n) -> STOP.
// Optional WAIT abort after TIMEOUT_CYCLES when built with WSM_TIMEOUT_EN.
module write_state_machine
    import wsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    write_state_machine_if.master bus
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               dir;
    logic               dir_nxt;
    logic               expire;
    logic               timeout_nxt;

`ifdef WSM_TIMEOUT_EN
    logic timeout_q;

    wsm_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (state == INIT),
        .count  (state == WAIT),
        .expire (expire)
    );
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYCLES ^ timeout_nxt;
`endif

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_nxt   = state;
        dir_nxt     = dir;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mr || bus.mw) begin
                    state_nxt = INIT;
                    dir_nxt   = bus.mw;
                end
            end
            INIT: state_nxt = WAIT;
            WAIT: begin
                if (!bus.ack_n) begin
                    state_nxt = STOP;
                end else if (expire) begin
                    state_nxt   = STOP;
                    timeout_nxt = 1'b1;
                end
            end
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            dir   <= 1'b0;
`ifdef WSM_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
`ifdef WSM_TIMEOUT_EN
            timeout_q <= timeout_nxt;
`endif
        end
    end

    // Moore decode: outputs depend only on state and the latched direction.
    always_comb begin
        bus.sm_state = state;
        bus.as_n     = 1'b1;
        bus.stop_n   = 1'b1;
        bus.wr_n     = 1'b1;
        bus.in_init  = 1'b0;
        bus.busy     = 1'b0;
        case (state)
            INIT: begin
                bus.as_n    = 1'b0;
                bus.wr_n    = ~dir;
                bus.in_init = 1'b1;
                bus.busy    = 1'b1;
            end
            WAIT: begin
                bus.as_n = 1'b0;
                bus.wr_n = ~dir;
                bus.busy = 1'b1;
            end
            STOP: begin
                bus.stop_n = 1'b0;
                bus.wr_n   = ~dir;
                bus.busy   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef WSM_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_write_state_machine.sv
// Scoreboard bench for write_state_machine: directed vectors push expected
// per-cycle outputs; a negedge monitor pops and compares. Honours WSM_TIMEOUT_EN.
module tb_write_state_machine;

    typedef struct {
        logic [1:0] st;
        logic       as_n;
        logic       stop_n;
        logic       wr_n;
        logic       in_init;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t sb[$];

    write_state_machine_if bus_if ();

    write_state_machine #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for the coming edge and record what the current cycle must show.
    task automatic step(input logic r, input logic w, input logic a,
                        input logic [1:0] st, input logic wr, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        e.st      = st;
        e.as_n    = !(st == 2'b01 || st == 2'b10);
        e.stop_n  = (st != 2'b11);
        e.wr_n    = wr;
        e.in_init = (st == 2'b01);
        e.busy    = (st != 2'b00);
        e.to      = to;
        sb.push_back(e);
        bus_if.mr    = r;
        bus_if.mw    = w;
        bus_if.ack_n = a;
    endtask

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sm_state", 8'(bus_if.sm_state), 8'(e.st));
                check("as_n",     8'(bus_if.as_n),     8'(e.as_n));
                check("stop_n",   8'(bus_if.stop_n),   8'(e.stop_n));
                check("wr_n",     8'(bus_if.wr_n),     8'(e.wr_n));
                check("in_init",  8'(bus_if.in_init),  8'(e.in_init));
                check("busy",     8'(bus_if.busy),     8'(e.busy));
                check("timeout",  8'(bus_if.timeout),  8'(e.to));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus_if.mr    = 1'b0;
        bus_if.mw    = 1'b0;
        bus_if.ack_n = 1'b1;

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",   8'(bus_if.sm_state), 8'h0);
        check("rst_as_n",    8'(bus_if.as_n),     8'h1);
        check("rst_stop_n",  8'(bus_if.stop_n),   8'h1);
        check("rst_wr_n",    8'(bus_if.wr_n),     8'h1);
        check("rst_busy",    8'(bus_if.busy),     8'h0);
        check("rst_in_init", 8'(bus_if.in_init),  8'h0);
        @(negedge clk);
        reset = 1'b1;

        // Write: one-cycle mw pulse, ack_n low in the third WAIT cycle.
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 0, 1, 2'd1, 0, 0);
        step(0, 0, 1, 2'd2, 0, 0);
        step(0, 0, 1, 2'd2, 0, 0);
        step(0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 1, 2'd3, 0, 0);
        step(0, 0, 0, 2'd0, 1, 0);   // ack_n low in IDLE: no effect

        // Read: mr held, ack_n low in the seventh WAIT cycle, restart from level.
        step(1, 0, 1, 2'd0, 1, 0);
        step(1, 0, 1, 2'd1, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 2'd2, 1, 0);
        step(1, 0, 0, 2'd2, 1, 0);
        step(1, 0, 1, 2'd3, 1, 0);
        step(1, 0, 1, 2'd0, 1, 0);
        step(0, 0, 0, 2'd1, 1, 0);   // ack_n low in INIT is ignored
        step(0, 0, 0, 2'd2, 1, 0);
        step(0, 0, 1, 2'd3, 1, 0);
        step(0, 0, 1, 2'd0, 1, 0);

        // Both requests high: write wins.
        step(1, 1, 1, 2'd0, 1, 0);
        step(0, 0, 1, 2'd1, 0, 0);
        step(0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 1, 2'd3, 0, 0);
        step(0, 0, 1, 2'd0, 1, 0);

        // Read with an mw pulse during WAIT: direction and state unaffected.
        step(1, 0, 1, 2'd0, 1, 0);
        step(0, 0, 1, 2'd1, 1, 0);
        step(0, 1, 1, 2'd2, 1, 0);
        step(0, 0, 0, 2'd2, 1, 0);
        step(0, 0, 1, 2'd3, 1, 0);
        step(0, 0, 1, 2'd0, 1, 0);

`ifdef WSM_TIMEOUT_EN
        // ack_n never low: four WAIT cycles, then STOP flagged as timeout.
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 0, 1, 2'd1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 2'd2, 0, 0);
        step(0, 0, 1, 2'd3, 0, 1);
        step(0, 0, 1, 2'd0, 1, 0);
        // ack_n low on the final count cycle: normal STOP, no timeout.
        step(1, 0, 1, 2'd0, 1, 0);
        step(0, 0, 1, 2'd1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd2, 1, 0);
        step(0, 0, 0, 2'd2, 1, 0);
        step(0, 0, 1, 2'd3, 1, 0);
        step(0, 0, 1, 2'd0, 1, 0);
`else
        // Without the timeout option WAIT holds indefinitely.
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 0, 1, 2'd1, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 0, 1, 2'd2, 0, 0);
        step(0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 1, 2'd3, 0, 0);
        step(0, 0, 1, 2'd0, 1, 0);
`endif

        // Async reset between edges while in WAIT.
        step(1, 0, 1, 2'd0, 1, 0);
        step(0, 0, 1, 2'd1, 1, 0);
        step(0, 0, 1, 2'd2, 1, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_state",  8'(bus_if.sm_state), 8'h0);
        check("arst_as_n",   8'(bus_if.as_n),     8'h1);
        check("arst_stop_n", 8'(bus_if.stop_n),   8'h1);
        check("arst_busy",   8'(bus_if.busy),     8'h0);
        @(posedge clk);
        #1;
        check("arst_hold",   8'(bus_if.sm_state), 8'h0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 1, 2'd0, 1, 0);
        step(0, 0, 1, 2'd0, 1, 0);

        @(negedge clk);
        #1;
        check("sb_drain", 8'(sb.size()), 8'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
